// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor reader: sequencer state encoding and the
// default widths/limits also used by the sensor interface and rate matcher.
package sensor_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 200;
  localparam int DEF_TMO_W   = 8;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RATE_ARM  = 3'd1,
    S_RATE_WAIT = 3'd2,
    S_REQ       = 3'd3,
    S_PRESENT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sensor_timeout_ctr.sv
// Cycle counter for the sensor request phase; expired_o is high on the cycle
// the count reaches LIMIT-1 while enabled.
module sensor_timeout_ctr #(
  parameter int TMO_W = 8,
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/sensor_read_sequencer.sv
// Sequences each sensor read: rate-match window -> request/ack with timeout ->
// valid/ready hand-off, with single-shot or continuous operation and abort.
module sensor_read_sequencer
  import sensor_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMO_W   = DEF_TMO_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              en_rate_matching_check,
  input  logic              done_rate_matching,
  output logic              sensor_req,
  input  logic              sensor_ack,
  input  logic [DATA_W-1:0] sensor_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  sample_count
);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              tmo_expired;

  sensor_timeout_ctr #(
    .TMO_W (TMO_W),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != S_REQ),
    .en_i      (state_q == S_REQ),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RATE_ARM;
        err_d   = 1'b0;
      end
      // done seen here is left over from the previous window
      S_RATE_ARM:  state_d = S_RATE_WAIT;
      S_RATE_WAIT: if (done_rate_matching) state_d = S_REQ;
      S_REQ: begin
        if (sensor_ack) begin
          state_d = S_PRESENT;
          data_d  = sensor_data;
        end else if (tmo_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_PRESENT: if (out_ready) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = continuous ? S_RATE_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort discards any captured sample but keeps count and error history
    if (abort) begin
      state_d = S_IDLE;
      data_d  = '0;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign en_rate_matching_check = (state_q == S_RATE_ARM) || (state_q == S_RATE_WAIT);
  assign sensor_req             = (state_q == S_REQ);
  assign out_valid              = (state_q == S_PRESENT);
  assign busy                   = (state_q != S_IDLE);
  assign out_data               = data_q;
  assign err_timeout            = err_q;
  assign sample_count           = cnt_q;

endmodule
